// File: rtl/seg_display_scheduler.sv
// Four-digit seven-segment scan controller that time-shares the display between
// four 16-bit debug sources, snapshotting the chosen source once per frame.
module seg_display_scheduler #(
    parameter int SCAN_DIV     = 16384,
    parameter int BLANK_CYCLES = 64,
    parameter int DWELL_FRAMES = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [63:0] src_data,
    input  logic [3:0]  src_req,
    input  logic        mode_auto,
    input  logic [1:0]  manual_sel,
    input  logic        freeze,
    output logic [3:0]  anode,
    output logic [7:0]  segment,
    output logic [1:0]  cur_src,
    output logic        frame_tick
);

    localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int DW   = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [15:0]   snap_q, snap_d;
    logic [1:0]    src_q, src_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    anode_q, anode_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick_q, tick_d;

    logic [1:0]    sel_src;
    logic [DW-1:0] sel_dwell;
    logic [7:0]    glyph;

    // Source choice for the next frame; only consumed at a frame boundary.
    always_comb begin
        sel_src   = src_q;
        sel_dwell = dwell_q;
        if (!mode_auto) begin
            sel_src   = manual_sel;
            sel_dwell = '0;
        end else if (src_req[src_q] && dwell_q != DWELL_LAST) begin
            sel_dwell = dwell_q + 1'b1;
        end else begin
            sel_dwell = '0;
            // Descending scan so the nearest requester after src_q wins.
            for (int k = 3; k >= 1; k--) begin
                if (src_req[src_q + 2'(k)]) sel_src = src_q + 2'(k);
            end
        end
    end

    assign glyph = hex7(snap_q[{digit_q, 2'b00} +: 4]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        snap_d  = snap_q;
        src_d   = src_q;
        dwell_d = dwell_q;
        anode_d = 4'hF;
        seg_d   = 8'hFF;
        tick_d  = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    anode_d = ~(4'b0001 << digit_q);
                    seg_d   = {glyph[7] & (digit_q != src_q), glyph[6:0]};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == SCAN_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                    if (digit_q == 2'd3) begin
                        tick_d = 1'b1;
                        if (!freeze) begin
                            src_d   = sel_src;
                            dwell_d = sel_dwell;
                            snap_d  = src_data[{sel_src, 4'b0000} +: 16];
                        end
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    anode_d = anode_q;
                    seg_d   = seg_q;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            digit_q <= 2'd0;
            snap_q  <= 16'h0000;
            src_q   <= 2'd0;
            dwell_q <= '0;
            anode_q <= 4'hF;
            seg_q   <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            snap_q  <= snap_d;
            src_q   <= src_d;
            dwell_q <= dwell_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign anode      = anode_q;
    assign segment    = seg_q;
    assign cur_src    = src_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: a frame-position reference model queues the
// expected digits of each frame, a negedge monitor pops and compares them.
module tb_seg_display_scheduler;

    localparam int SCAN  = 4;
    localparam int BLANK = 2;
    localparam int DWELL = 3;
    localparam int SLOT  = SCAN + BLANK;
    localparam int FRAME = 4 * SLOT;

    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clock;
    logic        reset_n;
    logic [63:0] src_data;
    logic [3:0]  src_req;
    logic        mode_auto;
    logic [1:0]  manual_sel;
    logic        freeze;
    logic [3:0]  anode;
    logic [7:0]  segment;
    logic [1:0]  cur_src;
    logic        frame_tick;

    seg_display_scheduler #(.SCAN_DIV(SCAN), .BLANK_CYCLES(BLANK), .DWELL_FRAMES(DWELL)) dut (
        .clock(clock), .reset_n(reset_n), .src_data(src_data), .src_req(src_req),
        .mode_auto(mode_auto), .manual_sel(manual_sel), .freeze(freeze),
        .anode(anode), .segment(segment), .cur_src(cur_src), .frame_tick(frame_tick)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0] anode;
        logic [7:0] seg;
    } exp_t;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] dwell;
    } sel_t;

    exp_t sbq[$];

    function automatic void push_frame(input logic [15:0] snap, input logic [1:0] cur);
        for (int d = 0; d < 4; d++) begin
            exp_t e;
            e.anode = ~(4'b0001 << d);
            e.seg   = HEX[snap[4*d +: 4]] & ((d == int'(cur)) ? 8'h7F : 8'hFF);
            sbq.push_back(e);
        end
    endfunction

    function automatic sel_t model_sel(input logic [1:0] cur, input logic [7:0] dw,
                                       input logic aut, input logic [1:0] man,
                                       input logic [3:0] req);
        sel_t r;
        r.src   = cur;
        r.dwell = dw;
        if (!aut) begin
            r.src   = man;
            r.dwell = 8'd0;
        end else if (req[cur] && int'(dw) < DWELL - 1) begin
            r.dwell = dw + 8'd1;
        end else begin
            r.dwell = 8'd0;
            for (int k = 1; k <= 3; k++) begin
                logic [1:0] c;
                c = 2'((int'(cur) + k) % 4);
                if (req[c]) begin
                    r.src = c;
                    break;
                end
            end
        end
        return r;
    endfunction

    // Reference state: position within the frame plus the selection state.
    int         m_pos;
    logic [1:0] m_cur;
    logic [7:0] m_dwell;
    logic [15:0] m_snap;
    logic       m_tick;
    sel_t       m_sel;

    assign m_sel = model_sel(m_cur, m_dwell, mode_auto, manual_sel, src_req);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_pos   <= 0;
            m_cur   <= 2'd0;
            m_dwell <= 8'd0;
            m_snap  <= 16'h0;
            m_tick  <= 1'b0;
            sbq.delete();
            push_frame(16'h0, 2'd0);
        end else if (m_pos == FRAME - 1) begin
            m_pos  <= 0;
            m_tick <= 1'b1;
            if (!freeze) begin
                m_cur   <= m_sel.src;
                m_dwell <= m_sel.dwell;
                m_snap  <= src_data[16*int'(m_sel.src) +: 16];
                push_frame(src_data[16*int'(m_sel.src) +: 16], m_sel.src);
            end else begin
                push_frame(m_snap, m_cur);
            end
        end else begin
            m_pos  <= m_pos + 1;
            m_tick <= 1'b0;
        end
    end

    initial begin
        exp_t cur_e;
        logic dark;
        cur_e = '{anode: 4'hF, seg: 8'hFF};
        forever begin
            @(negedge clock);
            if (reset_n) begin
                dark = (m_pos % SLOT) < BLANK;
                if (m_pos % SLOT == BLANK) begin
                    if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
                    else cur_e = sbq.pop_front();
                end
                chk("anode", anode, dark ? 4'hF : cur_e.anode);
                chk("segment", segment, dark ? 8'hFF : cur_e.seg);
                chk("cur_src", cur_src, m_cur);
                chk("frame_tick", frame_tick, m_tick);
            end
        end
    end

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_tick && n < 100);
        if (!frame_tick) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic skip(input int k);
        repeat (k) @(negedge clock);
    endtask

    initial begin
        int n;
        reset_n    = 1'b0;
        src_data   = 64'h0;
        src_req    = 4'h0;
        mode_auto  = 1'b0;
        manual_sel = 2'd2;
        freeze     = 1'b0;
        src_data[47:32] = 16'h1234;
        skip(3);
        chk("rst_anode", anode, 4'hF);
        chk("rst_segment", segment, 8'hFF);
        chk("rst_cur_src", cur_src, 2'd0);
        chk("rst_tick", frame_tick, 1'b0);
        #2 reset_n = 1'b1;

        // Initial frame: dark, then digit 0 with dp (snapshot 0, cur_src 0).
        skip(1);
        chk("t1_dark", anode, 4'hF);
        skip(1);
        chk("t1_d0_anode", anode, 4'hE);
        chk("t1_d0_seg", segment, 8'h40);
        skip(6);
        chk("t1_d1_anode", anode, 4'hD);
        chk("t1_d1_seg", segment, 8'hC0);

        // Manual selection of source 2.
        wait_tick(n);
        chk("t2_cur_src", cur_src, 2'd2);
        skip(2);
        chk("t2_d0_seg", segment, 8'h99);
        skip(12);
        chk("t2_d2_anode", anode, 4'hB);
        chk("t2_d2_seg", segment, 8'h24);
        wait_tick(n);
        wait_tick(n);
        chk("t2_period", n, FRAME);

        // Auto rotation from source 0 with sources 1 and 3 requesting.
        manual_sel = 2'd0;
        wait_tick(n);
        chk("t3_start", cur_src, 2'd0);
        skip(3);
        mode_auto = 1'b1;
        src_req   = 4'b1010;
        wait_tick(n);
        chk("t3_first", cur_src, 2'd1);
        wait_tick(n);
        wait_tick(n);
        chk("t3_dwell", cur_src, 2'd1);
        wait_tick(n);
        chk("t3_to3", cur_src, 2'd3);
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        chk("t3_to1", cur_src, 2'd1);

        // Freeze holds the captured snapshot while the source changes.
        mode_auto  = 1'b0;
        manual_sel = 2'd0;
        src_data[15:0] = 16'hBEEF;
        wait_tick(n);
        chk("t4_cur_src", cur_src, 2'd0);
        skip(3);
        freeze = 1'b1;
        src_data[15:0] = 16'h0000;
        wait_tick(n);
        skip(2);
        chk("t4_frozen1", segment, 8'h0E);
        wait_tick(n);
        skip(2);
        chk("t4_frozen2", segment, 8'h0E);
        skip(3);
        freeze = 1'b0;
        wait_tick(n);
        skip(2);
        chk("t4_released", segment, 8'h40);

        // Asynchronous reset during digit 2 drive.
        skip(12);
        chk("t5_d2_anode", anode, 4'hB);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_anode", anode, 4'hF);
        chk("t5_segment", segment, 8'hFF);
        chk("t5_cur_src", cur_src, 2'd0);
        chk("t5_tick", frame_tick, 1'b0);
        skip(2);
        manual_sel = 2'd1;
        #2 reset_n = 1'b1;

        // Auto with no requesters: source 1 holds, snapshot keeps refreshing.
        wait_tick(n);
        chk("t6_start", cur_src, 2'd1);
        skip(3);
        mode_auto = 1'b1;
        src_req   = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            wait_tick(n);
            chk("t6_hold", cur_src, 2'd1);
            skip(3);
            src_data[31:16] = 16'($urandom);
        end
        wait_tick(n);
        skip(FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
Scan controller and source scheduler for the board's 4-digit seven-segment debug display. It shares the display between four 16-bit debug sources: test_out low, test_out high, pc, and clock_count. Sources are chosen manually or by round-robin auto-rotation among requesting sources. The block snapshots the chosen value once per frame so digits never tear, and inserts blanking between digits to suppress ghosting.

Parameters:
SCAN_DIV, 16384, clock cycles each digit is driven (>=1)
BLANK_CYCLES, 64, clock cycles all digits are dark between digit drives (>=1)
DWELL_FRAMES, 256, frames a source stays shown in auto mode (>=1)

Ports:
clock  in  1  system clock
reset_n  in  1  reset
src_data  in  64  source i on bits [16i+15:16i], i=0..3
src_req  in  4  bit i: source i wants display time (auto mode only)
mode_auto  in  1  1 = auto rotation, 0 = manual
manual_sel  in  2  source index used in manual mode
freeze  in  1  hold current snapshot, source and dwell count
anode  out  4  digit enables, active-low
segment  out  8  active-low; [7]=dp, [6:0]=g..a
cur_src  out  2  index of source currently displayed
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- One clock. Reset is asynchronous and active-low, on reset_n.
- Reset values: anode=1111, segment=FF, cur_src=0, frame_tick=0, snapshot=0, digit=0, FSM=BLANK, all counters 0. Reset asserted mid-operation forces these values immediately, without a clock edge.
- Scan FSM states:
  - BLANK: lasts BLANK_CYCLES cycles. anode=1111, segment=FF. Then go to DRIVE.
  - DRIVE: lasts SCAN_DIV cycles. anode is low on the current digit only (d0=1110, d1=1101, d2=1011, d3=0111). segment=decode(snapshot[4d+3:4d]). Then digit=(digit+1) mod 4 and go to BLANK.
- Outputs are registered and show the new state's values on the first cycle of that state.
- Frame period is 4*(BLANK_CYCLES+SCAN_DIV) cycles.
- Hex decode, with dp off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E.
- dp: segment[7]=0 on the digit whose index equals cur_src, showing which source is displayed.
- Frame boundary: the edge that ends DRIVE of digit 3.
  - frame_tick=1 for exactly the first BLANK cycle of the new frame.
  - cur_src and snapshot update atomically at this edge: snapshot=src_data slice of the new cur_src.
  - No tick for the initial frame after reset.
- Selection at each boundary, when freeze=0:
  - Manual: cur_src=manual_sel. The dwell counter is cleared.
  - Auto: if src_req[cur_src]=0 or dwell=DWELL_FRAMES-1, advance to the first requesting index searching cur_src+1, +2, +3 (mod 4). On advance, dwell=0; otherwise dwell+1.
  - Auto, advance required but no other source requesting: keep cur_src if src_req[cur_src]=1, else keep cur_src anyway. dwell=0 in both cases.
  - Auto, src_req=0000: cur_src holds and the snapshot still refreshes.
- freeze=1 at a boundary: snapshot, cur_src and dwell all hold. The scan continues and frame_tick still pulses.
- Changes to mode_auto, manual_sel, src_req and src_data mid-frame have no visible effect until the next boundary.
- Counters are sized to the clog2 of their parameter. No overflow beyond the stated wrap points.

Test Plan:
(Parameters SCAN_DIV=4, BLANK_CYCLES=2, DWELL_FRAMES=3.)
1. Reset: hold reset_n=0 -> anode=1111, segment=FF, cur_src=0. Release -> 2 dark cycles, then anode=1110, segment=40 (0 with dp on digit 0) for 4 cycles, then 2 dark cycles, then 1101/C0.
2. Manual: mode_auto=0, manual_sel=2, source2=0x1234 -> after first frame_tick, cur_src=2 and digits read 1110/99, 1101/B0, 1011/24 (dp lit), 0111/F9. frame_tick pulses every 24 cycles.
3. Auto rotation: mode_auto=1, src_req=1010, start cur_src=0 -> cur_src=1 at the first boundary, 3 after 3 more frames, then 1 after 3 more.
4. Freeze/anti-tear: source0=0xBEEF captured; set freeze=1, change source0 to 0x0000 mid-frame -> display stays 0xBEEF across frames. Release freeze -> 0000 shown starting at the next boundary.
5. Async reset mid-DRIVE of digit 2: drop reset_n between clock edges -> anode=1111, segment=FF immediately; cur_src=0, no frame_tick.
6. Auto with src_req=0000, cur_src=1 -> cur_src stays 1 across 10 frames; snapshot follows a changing source1 each frame.
